// File: rtl/fp_align.sv
// Iterative exponent alignment ahead of the FP adder: picks the larger-exponent operand and
// sticky-shifts the other fraction right until the exponents match. Optional macro FP_ALIGN_SHIFT4_EN.
module fp_align (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  expA_i,
    input  logic [7:0]  expB_i,
    input  logic [26:0] fracA_i,
    input  logic [26:0] fracB_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        swapped_o,
    output logic [7:0]  expAligned_o,
    output logic [26:0] fracBig_o,
    output logic [26:0] fracSmall_o
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        swapped_q, swapped_d;
    logic [7:0]  exp_q, exp_d;
    logic [26:0] fbig_q, fbig_d;
    logic [26:0] fsmall_q, fsmall_d;

    logic        b_big;
    logic [7:0]  diff;
    logic [26:0] small_frac;

    // Bit 0 accumulates everything shifted past it, so the sticky is never lost.
    function automatic logic [26:0] shr1_sticky(input logic [26:0] f);
        return {1'b0, f[26:2], f[1] | f[0]};
    endfunction

    function automatic logic [26:0] shr4_sticky(input logic [26:0] f);
        return {4'b0, f[26:5], |f[4:0]};
    endfunction

    function automatic logic [26:0] flush_sticky(input logic [26:0] f);
        return {26'b0, |f};
    endfunction

    assign b_big      = (expB_i > expA_i);
    assign diff       = b_big ? (expB_i - expA_i) : (expA_i - expB_i);
    assign small_frac = b_big ? fracA_i : fracB_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        swapped_d = swapped_q;
        exp_d     = exp_q;
        fbig_d    = fbig_q;
        fsmall_d  = fsmall_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    swapped_d = b_big;
                    exp_d     = b_big ? expB_i : expA_i;
                    fbig_d    = b_big ? fracB_i : fracA_i;
                    fsmall_d  = small_frac;
                    cnt_d     = diff;
                    if (diff == 8'd0) begin
                        state_d = DONE;
                    end else if (diff >= 8'd27) begin
                        fsmall_d = flush_sticky(small_frac);
                        state_d  = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
`ifdef FP_ALIGN_SHIFT4_EN
                if (cnt_q >= 8'd4) begin
                    fsmall_d = shr4_sticky(fsmall_q);
                    cnt_d    = cnt_q - 8'd4;
                end else begin
                    fsmall_d = shr1_sticky(fsmall_q);
                    cnt_d    = cnt_q - 8'd1;
                end
`else
                fsmall_d = shr1_sticky(fsmall_q);
                cnt_d    = cnt_q - 8'd1;
`endif
                if (cnt_d == 8'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            swapped_q <= 1'b0;
            exp_q     <= 8'd0;
            fbig_q    <= 27'd0;
            fsmall_q  <= 27'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            swapped_q <= swapped_d;
            exp_q     <= exp_d;
            fbig_q    <= fbig_d;
            fsmall_q  <= fsmall_d;
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign swapped_o    = swapped_q;
    assign expAligned_o = exp_q;
    assign fracBig_o    = fbig_q;
    assign fracSmall_o  = fsmall_q;

endmodule

// File: tb/tb_fp_align.sv
// Bench for fp_align: directed scenarios plus randomized operands against an arithmetic model.
module tb_fp_align;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  expA = 8'd0, expB = 8'd0;
    logic [26:0] fracA = 27'd0, fracB = 27'd0;
    logic        busy, done, swapped;
    logic [7:0]  expAligned;
    logic [26:0] fracBig, fracSmall;

    int cyc = 0;
    int tT = 0;
    int n_pass = 0, n_tot = 0, n_fail = 0;

    fp_align dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .expA_i(expA), .expB_i(expB), .fracA_i(fracA), .fracB_i(fracB),
        .busy_o(busy), .done_o(done), .swapped_o(swapped),
        .expAligned_o(expAligned), .fracBig_o(fracBig), .fracSmall_o(fracSmall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int klat(input int d);
        if (d == 0 || d >= 27) return 0;
`ifdef FP_ALIGN_SHIFT4_EN
        return d / 4 + d % 4;
`else
        return d;
`endif
    endfunction

    // Exact right shift by d, with any lost nonzero bit folded into bit 0.
    function automatic logic [26:0] align_ref(input logic [26:0] f, input int d);
        logic [63:0] full, lost;
        logic [26:0] r;
        if (d >= 27) return {26'b0, |f};
        full = {37'b0, f};
        lost = full & ((64'd1 << d) - 64'd1);
        r = 27'(full >> d);
        if (lost != 64'd0) r[0] = 1'b1;
        return r;
    endfunction

    task automatic launch(input logic [7:0] ea, input logic [7:0] eb,
                          input logic [26:0] fa, input logic [26:0] fb);
        @(negedge clk);
        expA = ea; expB = eb; fracA = fa; fracB = fb; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        tT = cyc;
    endtask

    task automatic wait_done(output int lat);
        while (done !== 1'b1 && (cyc - tT) < 80) begin
            @(posedge clk);
            #1;
        end
        lat = cyc - tT;
    endtask

    task automatic run_op(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                          input logic [26:0] fa, input logic [26:0] fb);
        logic        sw;
        int          d, lat;
        logic [7:0]  e_exp;
        logic [26:0] e_big, e_small;
        sw      = (eb > ea);
        d       = sw ? int'(eb) - int'(ea) : int'(ea) - int'(eb);
        e_exp   = sw ? eb : ea;
        e_big   = sw ? fb : fa;
        e_small = align_ref(sw ? fa : fb, d);
        launch(ea, eb, fa, fb);
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        wait_done(lat);
        chk({tag, ".lat"}, 64'(lat), 64'(klat(d)));
        chk({tag, ".swapped"}, 64'(swapped), 64'(sw));
        chk({tag, ".exp"}, 64'(expAligned), 64'(e_exp));
        chk({tag, ".big"}, 64'(fracBig), 64'(e_big));
        chk({tag, ".small"}, 64'(fracSmall), 64'(e_small));
        @(posedge clk);
        #1;
        chk({tag, ".done_fall"}, {62'b0, busy, done}, 64'd0);
        chk({tag, ".hold"}, 64'(fracSmall), 64'(e_small));
    endtask

    initial begin
        int lat;
        logic seen;
        logic [7:0] ea, eb;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.ctrl", {61'b0, busy, done, swapped}, 64'd0);
        chk("reset.exp", 64'(expAligned), 64'd0);
        chk("reset.big", 64'(fracBig), 64'd0);
        chk("reset.small", 64'(fracSmall), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("basic", 8'd130, 8'd127, 27'h4000000, 27'h4000001);
        run_op("swap", 8'd100, 8'd101, 27'h4000003, 27'h4000000);
        run_op("equal", 8'd127, 8'd127, 27'h4123456, 27'h7654321);
        run_op("flush", 8'd200, 8'd10, 27'h4000000, 27'h0000100);
        run_op("flush0", 8'd10, 8'd37, 27'h0000000, 27'h5555555);
        run_op("d26", 8'd26, 8'd0, 27'h7FFFFFF, 27'h4000000);

        // Busy guard: second start lands while the first op is still shifting.
        launch(8'd150, 8'd130, 27'h4000000, 27'h4ABCDEF);
        repeat (4) @(negedge clk);
        expA = 8'd1; expB = 8'd9; fracA = 27'h1; fracB = 27'h2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        chk("guard.lat", 64'(lat), 64'(klat(20)));
        chk("guard.swapped", 64'(swapped), 64'd0);
        chk("guard.exp", 64'(expAligned), 64'd150);
        chk("guard.small", 64'(fracSmall), 64'(align_ref(27'h4ABCDEF, 20)));
        @(posedge clk);
        #1;
        chk("guard.idle", {62'b0, busy, done}, 64'd0);

        // Reset in the middle of a long shift.
        launch(8'd150, 8'd130, 27'h4000000, 27'h4ABCDEF);
        seen = 1'b0;
        repeat (7) begin
            @(negedge clk);
            seen = seen | done;
        end
`ifndef FP_ALIGN_SHIFT4_EN
        chk("rst.nodone_before", 64'(seen), 64'd0);
`endif
        rst = 1'b1;
        #1;
        chk("rst.outs", {busy, done, swapped, expAligned, fracBig, fracSmall}, 64'd0);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen = seen | done | busy;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | done | busy;
        end
        chk("rst.quiet", 64'(seen), 64'd0);
        run_op("after_rst", 8'd64, 8'd65, 27'h4000001, 27'h4000002);

        for (int i = 0; i < 40; i++) begin
            ea = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) eb = 8'($urandom_range(0, 255));
            else if ($urandom_range(0, 1) == 0) eb = (ea > 8'd227) ? 8'd255 : ea + 8'($urandom_range(0, 28));
            else eb = (ea < 8'd28) ? 8'd0 : ea - 8'($urandom_range(0, 28));
            run_op($sformatf("rnd%0d", i), ea, eb,
                   27'($urandom) | 27'h4000000, 27'($urandom) | 27'h4000000);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
